csram_arbiter: RTL
==================

Name: csram_arbiter

Overview:
- Two-master arbiter for the single-port CSRAM (`cmsdk_fpga_sram`, 1-cycle registered read).
- Shares the RAM between the UART debug bridge port (dbg) and the DMA engine port (dma).
- Arbitration: round-robin on contention, plus an optional lock for atomic or burst sequences.
- Tracks the owner of each in-flight read and routes returned data to that master only.

Parameters:
- AW, 10, word-address width (CSRAM_ADDR_WIDTH-2).
- DW, 32, data width; byte-enable width is DW/8.
- MAX_BURST, 16, maximum consecutive locked grants before a forced release; range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- dbg_req_i  in  1  dbg access request
- dbg_we_i  in  1  1=write, 0=read
- dbg_be_i  in  DW/8  byte enables (writes only)
- dbg_addr_i  in  AW  word address
- dbg_wdata_i  in  DW  write data
- dbg_lock_i  in  1  hold ownership after grant
- dbg_gnt_o  out  1  request accepted this cycle
- dbg_rvalid_o  out  1  read data valid
- dbg_rdata_o  out  DW  read data
- dma_req_i / dma_we_i / dma_be_i / dma_addr_i / dma_wdata_i / dma_lock_i  in  same widths as dbg
- dma_gnt_o / dma_rvalid_o / dma_rdata_o  out  same widths as dbg
- sram_cs_o  out  1  RAM select, active-high
- sram_wren_o  out  DW/8  per-byte write enable
- sram_addr_o  out  AW  RAM address
- sram_wdata_o  out  DW  RAM write data
- sram_rdata_i  in  DW  RAM read data, valid the cycle after a read select
- owner_o  out  2  lock status: 00 none, 01 dbg, 10 dma

Behaviour:
- Reset: every registered state and output is 0; rr pointer favours dbg; lock released; burst counter 0.
  - sram_* outputs are don't-care but are driven to 0 when idle.
- Grant is combinational from req/state in the same cycle. At most one gnt per cycle. gnt is only asserted together with its req.
- Grant decision, in priority order:
  1. Locked to X: only X can be granted. The other master waits even while X is idle.
  2. Unlocked, single requester: that requester is granted.
  3. Unlocked, both requesting: the master indicated by rr is granted; rr then points to the other master.
- rr updates only on contended grants.
- Granted cycle:
  - sram_cs_o=1; sram_addr_o and sram_wdata_o muxed from the winner.
  - sram_wren_o = winner be when we=1, else 0.
  - be=0 write: cs still asserted, no bytes change, grant is still given.
- No grant: sram_cs_o=0, sram_wren_o=0.
- Reads:
  - A one-bit pending register plus owner tag is set on a granted read.
  - Next cycle: the owner's rvalid_o=1 and rdata_o=sram_rdata_i.
  - The non-owner's rvalid stays 0 and its rdata is held at 0.
- Throughput: one access per cycle, back-to-back. A read followed by any grant next cycle is legal because the RAM is pipelined.
- Lock:
  - Acquired on any grant to X with lock_i=1; owner_o shows X.
  - The burst counter counts grants while locked; the acquiring grant counts as 1.
  - Release occurs on the first cycle X has lock_i=0, regardless of req. Unlocked arbitration applies in that same cycle.
  - Forced release occurs after the MAX_BURST-th locked grant: counter cleared, rr points to the other master.
  - After a forced release, X may re-lock only on a subsequent grant.
- Simultaneous release and contention: the release takes effect first, then rr decides.
- Reset mid-operation: the pending read is discarded, so no rvalid in the cycle after reset, and the lock is cleared.
- Requesters must hold req and payload stable until gnt; the arbiter does not check this.

Test Plan:
- dbg write addr 0x005, data 0xDEADBEEF, be 4'hF, then dbg read 0x005 -> both gnt same cycle as req; dbg_rvalid_o one cycle after the read grant with 0xDEADBEEF; dma_rvalid_o stays 0.
- After reset, both masters continuously issue reads to distinct addresses -> grants alternate dbg, dma, dbg, dma; each rvalid goes only to the matching master with correct data.
- Address 0x020 holds 0x11223344; dma write be=4'b0010 data 0x0000AB00 -> a dma read of 0x020 returns 0x1122AB44; sram_wren_o observed as 4'b0010 during the write.
- dma lock_i=1 with continuous requests, dbg requesting throughout -> dma gets exactly 16 consecutive grants, then dbg is granted on the 17th cycle; owner_o goes 10 -> 00.
- dbg acquires the lock, drops req for 3 cycles with lock_i held, dma requesting -> no dma_gnt for those 3 cycles; dbg drops lock_i -> dma_gnt in that same cycle.
- rst_i asserted the cycle after a dbg read grant -> dbg_rvalid_o=0 in the following cycle, all outputs 0, and the first contended grant after reset goes to dbg.

Source files
------------

// File: rtl/csram_arbiter.sv
// csram_arbiter
//   Two-master arbiter for the single-port CSRAM (1-cycle registered read).
//   Shares the RAM between the UART debug bridge (dbg) and the DMA engine
//   (dma). Uses round-robin on contention. A master can lock ownership for
//   atomic or burst sequences, and the lock is forcibly dropped after
//   MAX_BURST locked grants. Read data is routed only to the master that
//   issued the read.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   dbg_* / dma_* (inputs)   req, we, be, addr, wdata, lock per master
//   dbg_* / dma_* (outputs)  gnt (combinational), rvalid, rdata
//   sram_cs_o/wren_o/addr_o/wdata_o  RAM request side, 0 when idle
//   sram_rdata_i             RAM read data, valid the cycle after a read select
//   owner_o                  lock status: 00 none, 01 dbg, 10 dma
module csram_arbiter #(
    parameter int unsigned AW        = 10,
    parameter int unsigned DW        = 32,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            dbg_req_i,
    input  logic            dbg_we_i,
    input  logic [DW/8-1:0] dbg_be_i,
    input  logic [AW-1:0]   dbg_addr_i,
    input  logic [DW-1:0]   dbg_wdata_i,
    input  logic            dbg_lock_i,
    output logic            dbg_gnt_o,
    output logic            dbg_rvalid_o,
    output logic [DW-1:0]   dbg_rdata_o,

    input  logic            dma_req_i,
    input  logic            dma_we_i,
    input  logic [DW/8-1:0] dma_be_i,
    input  logic [AW-1:0]   dma_addr_i,
    input  logic [DW-1:0]   dma_wdata_i,
    input  logic            dma_lock_i,
    output logic            dma_gnt_o,
    output logic            dma_rvalid_o,
    output logic [DW-1:0]   dma_rdata_o,

    output logic            sram_cs_o,
    output logic [DW/8-1:0] sram_wren_o,
    output logic [AW-1:0]   sram_addr_o,
    output logic [DW-1:0]   sram_wdata_o,
    input  logic [DW-1:0]   sram_rdata_i,

    output logic [1:0]      owner_o
);

    typedef enum logic [1:0] {
        LK_NONE = 2'b00,
        LK_DBG  = 2'b01,
        LK_DMA  = 2'b10
    } lock_e;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    lock_e      lock_q, lock_d, lock_eff;
    logic       rr_q, rr_d;            // 0: dbg favoured, 1: dma favoured
    logic [7:0] burst_q, burst_d;
    logic [7:0] burst_base, burst_nx;
    logic       pend_q, pend_d;
    logic       pend_dma_q;            // owner tag of the in-flight read
    logic       gnt_dbg, gnt_dma, any_gnt, contended, win_lock, win_we;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= LK_NONE;
            rr_q       <= 1'b0;
            burst_q    <= '0;
            pend_q     <= 1'b0;
            pend_dma_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            rr_q       <= rr_d;
            burst_q    <= burst_d;
            pend_q     <= pend_d;
            pend_dma_q <= gnt_dma;
        end
    end

    // Grant decision and next state
    always_comb begin
        lock_eff   = lock_q;
        gnt_dbg    = 1'b0;
        gnt_dma    = 1'b0;
        contended  = 1'b0;
        lock_d     = LK_NONE;
        rr_d       = rr_q;
        burst_d    = '0;
        burst_base = '0;
        burst_nx   = '0;

        // A lock holder dropping lock_i releases in this same cycle, so the
        // unlocked arbitration below already sees the released state.
        if (lock_q == LK_DBG && !dbg_lock_i) lock_eff = LK_NONE;
        if (lock_q == LK_DMA && !dma_lock_i) lock_eff = LK_NONE;

        case (lock_eff)
            LK_DBG:  gnt_dbg = dbg_req_i;
            LK_DMA:  gnt_dma = dma_req_i;
            default: begin
                if (dbg_req_i && dma_req_i) begin
                    contended = 1'b1;
                    gnt_dma   = rr_q;
                    gnt_dbg   = !rr_q;
                end else begin
                    gnt_dbg = dbg_req_i;
                    gnt_dma = dma_req_i;
                end
            end
        endcase

        any_gnt  = gnt_dbg | gnt_dma;
        win_lock = gnt_dma ? dma_lock_i : (gnt_dbg & dbg_lock_i);
        win_we   = gnt_dma ? dma_we_i   : dbg_we_i;
        pend_d   = any_gnt & ~win_we;

        // rr points away from the winner; rr_d = gnt_dbg covers both the
        // contended case and a forced release (the locked master is the winner).
        if (contended) rr_d = gnt_dbg;

        lock_d     = lock_eff;
        burst_base = (lock_eff == LK_NONE) ? '0 : burst_q;
        burst_d    = burst_base;

        if (any_gnt && win_lock) begin
            burst_nx = burst_base + 8'd1;
            if (burst_nx >= MAX_B) begin
                lock_d  = LK_NONE;
                burst_d = '0;
                rr_d    = gnt_dbg;
            end else begin
                lock_d  = gnt_dma ? LK_DMA : LK_DBG;
                burst_d = burst_nx;
            end
        end
    end

    // RAM request mux
    always_comb begin
        sram_cs_o    = any_gnt;
        sram_wren_o  = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (gnt_dma) begin
            sram_wren_o  = dma_we_i ? dma_be_i : '0;
            sram_addr_o  = dma_addr_i;
            sram_wdata_o = dma_wdata_i;
        end else if (gnt_dbg) begin
            sram_wren_o  = dbg_we_i ? dbg_be_i : '0;
            sram_addr_o  = dbg_addr_i;
            sram_wdata_o = dbg_wdata_i;
        end
    end

    // Read return routing
    always_comb begin
        dbg_gnt_o    = gnt_dbg;
        dma_gnt_o    = gnt_dma;
        dbg_rvalid_o = pend_q & ~pend_dma_q;
        dma_rvalid_o = pend_q &  pend_dma_q;
        dbg_rdata_o  = dbg_rvalid_o ? sram_rdata_i : '0;
        dma_rdata_o  = dma_rvalid_o ? sram_rdata_i : '0;
        owner_o      = lock_q;
    end

endmodule
